dct2d_ctrl: RTL
===============

Name: dct2d_ctrl

Overview:
- Sequencer for the two-stage 2D DCT datapath: stage-1 dct32, scaling1, transpose buffer, stage-2 dct32, scaling2.
- Accepts one row of residuals per cycle through a valid/ready handshake.
- Pulses the stage-1 load, transpose load/unload and stage-2 load for exactly N rows/columns, where N follows the block size.
- Flags valid output coefficient columns with an index and a last marker, and latches block size so both scaling stages see a stable value per block.

Parameters:
- LAT1, 1: cycles from load_1dct to stage-1/scaling1 result valid at transpose input.
- LAT2, 1: cycles from load_2dct to scaling2 result valid at y outputs.
- CNT_W, 5: width of row/column counters (holds 0..31).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of current block
- size  in  2  block size request: 00=4, 01=8, 10=16, 11=32
- in_valid  in  1  input row present on x0..x31
- in_ready  out  1  controller can accept a row
- load_1dct  out  1  stage-1 load enable
- load_trans  out  1  transpose write enable (row in)
- unload_trans  out  1  transpose read enable (column out)
- load_2dct  out  1  stage-2 load enable
- size_q  out  2  latched block size, drives scaling1/scaling2
- out_valid  out  1  y0..y31 hold a valid coefficient column
- out_idx  out  CNT_W  column index of current output
- out_last  out  1  final column of block
- busy  out  1  state != IDLE or output delay line non-empty

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters, delay lines, strobes, out_valid, out_idx, out_last = 0; size_q=2'b11; in_ready=0 during reset.
- N = 4 << size_q.
- States: IDLE, ROW, WAIT_T, COL.
- IDLE:
  - in_ready=1.
  - On in_valid: size_q<=size, row_cnt<=1, load_1dct=1 this cycle, go to ROW (or WAIT_T if N reached, impossible since N>=4).
- ROW:
  - in_ready=1; load_1dct = in_valid & in_ready, combinational, same cycle as the accept.
  - row_cnt increments per accept; on accept with row_cnt==N-1 go to WAIT_T.
  - Gaps (in_valid=0) are allowed and do not advance.
- load_trans:
  - Is load_1dct delayed LAT1 cycles through a shift register, independent of state.
  - trans_cnt counts load_trans pulses.
- WAIT_T:
  - in_ready=0.
  - When load_trans=1 and trans_cnt==N-1, go to COL next cycle; clear trans_cnt.
- COL:
  - in_ready=0; unload_trans=load_2dct=1 every cycle; col_cnt 0..N-1.
  - After col_cnt==N-1, go to IDLE (transpose buffer free; next block may start the following cycle).
- Output:
  - out_valid = load_2dct delayed LAT2.
  - out_idx = col_cnt delayed LAT2.
  - out_last = out_valid & (out_idx==N-1 of the block that issued it). Delay N/last alongside, because size_q may change for the next block while the delay line drains.
- Overlap: the next block's ROW phase may run while prior columns are still in the output delay line. size_q change is allowed only from IDLE.
- Latency (LAT1=LAT2=1): last row accepted at cycle t → first column unload t+2 → first out_valid t+3 → out_last at t+2+N.
- flush (sync, higher priority than all else):
  - state=IDLE; counters and both delay lines cleared.
  - out_valid=0 from the next cycle; in_ready=0 in the flush cycle.
- in_valid while in_ready=0: ignored, no strobe.
- Counters never wrap: transitions fire at N-1 exactly.

Decomposition:
- Shared package (dct_pkg): state encoding (IDLE/ROW/WAIT_T/COL), size codes, the N-from-size function, CNT_W.
- One natural sub-module: dct_delay_line (parameterised depth and width, async active-low clear plus sync flush). Instantiate it for load_trans, and for the out_valid/out_idx/out_last bundle.

Test Plan:
- size=00, 4 back-to-back rows from IDLE at cycle 0:
  - load_1dct at cycles 0-3; load_trans at 1-4.
  - unload_trans/load_2dct at 5-8; out_valid at 6-9 with out_idx 0,1,2,3; out_last at 9; in_ready=0 at 4-8, 1 at 9.
- size=11, in_valid toggling 1,0 each cycle:
  - exactly 32 load_1dct pulses and 32 load_trans pulses, then 32 consecutive load_2dct.
  - out_last on out_idx=31 only; busy falls one cycle after out_last.
- Block A size=01, then block B size=10 presented immediately in IDLE:
  - B rows are accepted while A's last out_valid drains; size_q switches to 10 only at B's first accept.
  - A's out_last at out_idx=7, B's at 15.
- flush asserted in COL with col_cnt=3, size=10:
  - next cycle state=IDLE, unload_trans=0, out_valid=0 from the following cycle, no out_last.
  - A new block then completes normally.
- rst deasserted-to-0 asynchronously mid-ROW (row_cnt=5): all outputs 0 immediately; after release, in_ready=1 and size_q=11.
- in_valid held high during WAIT_T/COL: no extra load_1dct; the first accept happens the cycle after COL ends.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: shared types and helpers for the 2D DCT sequencer.
// State encoding, block size codes and the size-to-N mapping.
package dct_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_WAIT_T,
    ST_COL
  } state_e;

  localparam logic [1:0] SZ_4  = 2'b00;
  localparam logic [1:0] SZ_8  = 2'b01;
  localparam logic [1:0] SZ_16 = 2'b10;
  localparam logic [1:0] SZ_32 = 2'b11;

  function automatic int unsigned n_of(input logic [1:0] s);
    int unsigned n;
    n = 4;
    unique case (s)
      SZ_4:  n = 4;
      SZ_8:  n = 8;
      SZ_16: n = 16;
      SZ_32: n = 32;
      default: n = 4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dct_delay_line.sv
// dct_delay_line: fixed-depth shift register with async clear and sync flush.
// pending reports whether bit 0 of any stage is set.
module dct_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pending
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) pending = pending | sr[i][0];
  end

endmodule

// File: rtl/dct2d_ctrl.sv
// dct2d_ctrl: row/column sequencer for the two-pass 2D DCT datapath.
// Drives stage-1, transpose and stage-2 strobes and tags output columns.
module dct2d_ctrl
  import dct_pkg::*;
#(
  parameter int LAT1  = 1,
  parameter int LAT2  = 1,
  parameter int CNT_W = dct_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       size,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_1dct,
  output logic             load_trans,
  output logic             unload_trans,
  output logic             load_2dct,
  output logic [1:0]       size_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int OW = CNT_W + 2;

  state_e           state;
  state_e           state_d;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] trans_cnt;
  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] last_q;
  logic             row_end;
  logic             trans_end;
  logic             col_end;
  logic             trans_pend;
  logic             out_pend;
  logic [OW-1:0]    out_d;
  logic [OW-1:0]    out_q;

  assign last_q    = CNT_W'(n_of(size_q) - 1);
  assign row_end   = row_cnt == last_q;
  assign trans_end = load_trans && (trans_cnt == last_q);
  assign col_end   = col_cnt == last_q;

  always_comb begin
    state_d      = state;
    in_ready     = 1'b0;
    unload_trans = 1'b0;
    load_2dct    = 1'b0;
    unique case (state)
      ST_IDLE, ST_ROW: in_ready = rst & ~flush;
      ST_COL: begin
        unload_trans = ~flush;
        load_2dct    = ~flush;
      end
      default: ;
    endcase
    load_1dct = in_valid & in_ready;
    unique case (state)
      ST_IDLE:   if (load_1dct) state_d = ST_ROW;
      ST_ROW:    if (load_1dct && row_end) state_d = ST_WAIT_T;
      ST_WAIT_T: if (trans_end) state_d = ST_COL;
      ST_COL:    if (col_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // size_q only moves on the first row of a block, so scaling sees one size per block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      size_q    <= SZ_32;
      row_cnt   <= '0;
      trans_cnt <= '0;
      col_cnt   <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      trans_cnt <= '0;
      col_cnt   <= '0;
    end else begin
      state <= state_d;
      if (load_1dct) begin
        if (state == ST_IDLE) begin
          size_q  <= size;
          row_cnt <= CNT_W'(1);
        end else begin
          row_cnt <= row_end ? '0 : row_cnt + CNT_W'(1);
        end
      end
      if (load_trans)
        trans_cnt <= trans_end ? '0 : trans_cnt + CNT_W'(1);
      if (load_2dct)
        col_cnt <= col_end ? '0 : col_cnt + CNT_W'(1);
    end
  end

  dct_delay_line #(
    .DEPTH(LAT1),
    .WIDTH(1)
  ) u_trans (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .d       (load_1dct),
    .q       (load_trans),
    .pending (trans_pend)
  );

  // last travels with the column so a new block's size cannot retag it
  assign out_d = {load_2dct & col_end, col_cnt, load_2dct};

  dct_delay_line #(
    .DEPTH(LAT2),
    .WIDTH(OW)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .d       (out_d),
    .q       (out_q),
    .pending (out_pend)
  );

  assign out_valid = out_q[0];
  assign out_idx   = out_q[CNT_W:1];
  assign out_last  = out_q[OW-1];
  assign busy      = (state != ST_IDLE) | trans_pend | out_pend;

endmodule
